// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO queue controller: register map, STATUS/CTRL bit
// positions and the operation type produced by the address decode.
package mmio_fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH = 8;

   localparam logic [15:0] OFF_DATA   = 16'd0;
   localparam logic [15:0] OFF_STATUS = 16'd2;
   localparam logic [15:0] OFF_CTRL   = 16'd4;
   localparam logic [15:0] OFF_PEEK   = 16'd6;

   localparam int unsigned ST_EMPTY     = 16;
   localparam int unsigned ST_FULL      = 17;
   localparam int unsigned ST_OVERFLOW  = 18;
   localparam int unsigned ST_UNDERFLOW = 19;
   localparam int unsigned ST_DEPTH_LSB = 32;

   localparam int unsigned CTRL_FLUSH      = 0;
   localparam int unsigned CTRL_CLR_STICKY = 1;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_PEEK,
      OP_STATUS,
      OP_CTRL
   } t_mmio_fifo_op;

   // Writes to STATUS/PEEK fall inside the window but have no effect.
   function automatic t_mmio_fifo_op decode_op(input logic [15:0] addr,
                                               input logic [15:0] base,
                                               input logic        is_rd);
      logic [15:0] off;
      off = addr - base;
      decode_op = OP_NONE;
      case (off)
         OFF_DATA:   decode_op = is_rd ? OP_POP : OP_PUSH;
         OFF_STATUS: decode_op = is_rd ? OP_STATUS : OP_NONE;
         OFF_CTRL:   decode_op = OP_CTRL;
         OFF_PEEK:   decode_op = is_rd ? OP_PEEK : OP_NONE;
         default:    decode_op = OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mmio_fifo_store.sv
// Circular buffer of 64-bit entries with an explicit occupancy counter so full
// and empty never alias.
module mmio_fifo_store
   import mmio_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [63:0]              push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [63:0]              head_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [63:0]     mem_q [DEPTH];
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;

   assign full_o      = (count_q == CntW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign head_data_o = mem_q[head_q];
   assign count_o     = count_q;

   // A push while full is still accepted if the same cycle frees an entry.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_i);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) tail_d = tail_q + 1'b1;
         if (pop_ok)  head_d = head_q + 1'b1;
         count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[tail_q] <= push_data_i;
   end

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped queue controller: decodes the 4-register window, keeps the sticky
// error flags and registers the single-cycle read response.
module mmio_fifo_ctrl
   import mmio_fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter logic [15:0] BASE_ADDR = 16'h0020
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   input  logic [15:0]            wr_addr,
   input  logic [63:0]            wr_data,
   input  logic                   rd_valid,
   input  logic [15:0]            rd_addr,
   input  logic [8:0]             rd_tid,
   output logic                   rsp_valid,
   output logic [8:0]             rsp_tid,
   output logic [63:0]            rsp_data,
   output logic [$clog2(DEPTH):0] count
);

   t_mmio_fifo_op wr_op, rd_op;
   logic          push, pop, flush, clr_sticky;
   logic          full, empty;
   logic [63:0]   head_data, status_word;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [8:0]    rsp_tid_q, rsp_tid_d;
   logic [63:0]   rsp_data_q, rsp_data_d;

   assign wr_op = wr_valid ? decode_op(wr_addr, BASE_ADDR, 1'b0) : OP_NONE;
   assign rd_op = rd_valid ? decode_op(rd_addr, BASE_ADDR, 1'b1) : OP_NONE;

   assign push       = (wr_op == OP_PUSH);
   assign pop        = (rd_op == OP_POP);
   assign flush      = (wr_op == OP_CTRL) && wr_data[CTRL_FLUSH];
   assign clr_sticky = (wr_op == OP_CTRL) && wr_data[CTRL_CLR_STICKY];

   mmio_fifo_store #(
      .DEPTH(DEPTH)
   ) u_store (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (push),
      .push_data_i(wr_data),
      .pop_i      (pop),
      .flush_i    (flush),
      .full_o     (full),
      .empty_o    (empty),
      .head_data_o(head_data),
      .count_o    (count)
   );

   always_comb begin
      status_word                         = '0;
      status_word[15:0]                   = 16'(count);
      status_word[ST_EMPTY]               = empty;
      status_word[ST_FULL]                = full;
      status_word[ST_OVERFLOW]            = ovf_q;
      status_word[ST_UNDERFLOW]           = udf_q;
      status_word[ST_DEPTH_LSB +: 16]     = 16'(DEPTH);
   end

   // Clear is applied first so an error in the same cycle is not lost.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (clr_sticky) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (push && full && !pop) ovf_d = 1'b1;
      if (pop && empty)         udf_d = 1'b1;
   end

   always_comb begin
      rsp_valid_d = (rd_op != OP_NONE);
      rsp_tid_d   = rsp_tid_q;
      rsp_data_d  = rsp_data_q;
      if (rsp_valid_d) begin
         rsp_tid_d = rd_tid;
         case (rd_op)
            OP_POP, OP_PEEK: rsp_data_d = empty ? 64'h0 : head_data;
            OP_STATUS:       rsp_data_d = status_word;
            default:         rsp_data_d = 64'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tid   = rsp_tid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Self-checking bench for mmio_fifo_ctrl: a queue-based reference model checked
// every cycle, plus directed reads with literal expected values.
module tb_mmio_fifo_ctrl;

   localparam int unsigned DEPTH = 8;
   localparam logic [15:0] BASE  = 16'h0020;
   localparam logic [15:0] A_DATA = 16'h0020, A_STAT = 16'h0022, A_CTRL = 16'h0024;
   localparam logic [15:0] A_PEEK = 16'h0026;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0, rd_valid = 1'b0;
   logic [15:0] wr_addr = '0, rd_addr = '0;
   logic [63:0] wr_data = '0;
   logic [8:0]  rd_tid = '0;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   logic [8:0] tid_ctr = 9'd5;

   // Reference model state
   logic [63:0] q[$];
   bit          m_ovf = 0, m_udf = 0;
   logic        e_valid = 1'b0;
   logic [8:0]  e_tid = '0;
   logic [63:0] e_data = '0;

   mmio_fifo_ctrl #(
      .DEPTH    (DEPTH),
      .BASE_ADDR(BASE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_addr  (rd_addr),
      .rd_tid   (rd_tid),
      .rsp_valid(rsp_valid),
      .rsp_tid  (rsp_tid),
      .rsp_data (rsp_data),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Window offset of an address, or -1 when outside the four registers.
   function automatic int win(input logic [15:0] a);
      int k;
      k = int'(a) - int'(BASE);
      if (k == 0 || k == 2 || k == 4 || k == 6) return k;
      return -1;
   endfunction

   initial begin : model
      int  n, roff, woff;
      bit  popped, pre_ovf, pre_udf;
      forever begin
         @(posedge clk);
         if (rst) begin
            q.delete();
            m_ovf = 0; m_udf = 0;
            e_valid = 1'b0; e_tid = '0; e_data = '0;
         end else begin
            n = q.size();
            popped = 0;
            pre_ovf = m_ovf; pre_udf = m_udf;
            roff = rd_valid ? win(rd_addr) : -1;
            woff = wr_valid ? win(wr_addr) : -1;
            if (woff == 4 && wr_data[1]) begin m_ovf = 0; m_udf = 0; end
            if (roff >= 0) begin
               e_valid = 1'b1;
               e_tid = rd_tid;
               case (roff)
                  0: if (n > 0) begin e_data = q.pop_front(); popped = 1; end
                     else begin e_data = 64'h0; m_udf = 1; end
                  2: e_data = {16'h0, 16'(DEPTH), 12'h0, pre_udf, pre_ovf,
                               (n == DEPTH), (n == 0), 16'(n)};
                  6: e_data = (n > 0) ? q[0] : 64'h0;
                  default: e_data = 64'h0;
               endcase
            end else begin
               e_valid = 1'b0;
            end
            if (woff == 0) begin
               if (n < DEPTH || popped) q.push_back(wr_data);
               else m_ovf = 1;
            end
            if (woff == 4 && wr_data[0]) q.delete();
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
            chk("rsp_tid", 64'(rsp_tid), 64'(e_tid));
            chk("rsp_data", rsp_data, e_data);
            chk("count", 64'(count), 64'(q.size()));
         end
      end
   end

   task automatic step(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [15:0] ra);
      @(negedge clk);
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr = ra; rd_tid = tid_ctr;
      tid_ctr = tid_ctr + 9'd1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      step(1'b1, a, d, 1'b0, 16'h0);
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 64'h0, 1'b0, 16'h0);
   endtask

   task automatic rd_exp(input string name, input logic [15:0] a, input logic [63:0] exp);
      step(1'b0, 16'h0, 64'h0, 1'b1, a);
      @(posedge clk); #1;
      chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
      chk(name, rsp_data, exp);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state and STATUS after reset, TID echo
      tid_ctr = 9'd5;
      rd_exp("status_reset", A_STAT, 64'h0000_0008_0001_0000);
      chk("tid_echo", 64'(rsp_tid), 64'd5);

      // Basic push / peek / pop
      wr(A_DATA, 64'hA1); wr(A_DATA, 64'hA2); wr(A_DATA, 64'hA3);
      rd_exp("peek", A_PEEK, 64'hA1);
      chk("count_after_peek", 64'(count), 64'd3);
      rd_exp("pop1", A_DATA, 64'hA1);
      rd_exp("pop2", A_DATA, 64'hA2);
      rd_exp("pop3", A_DATA, 64'hA3);
      rd_exp("status_empty", A_STAT, 64'h0000_0008_0001_0000);

      // Overflow: ninth push dropped
      for (int i = 0; i < 9; i++) wr(A_DATA, 64'h100 + 64'(i));
      rd_exp("status_full_ovf", A_STAT, 64'h0000_0008_0006_0008);
      for (int i = 0; i < 8; i++) rd_exp("pop_ovf", A_DATA, 64'h100 + 64'(i));
      rd_exp("status_ovf_sticky", A_STAT, 64'h0000_0008_0005_0000);
      wr(A_CTRL, 64'h2);

      // Pointer wrap
      for (int i = 0; i < 6; i++) wr(A_DATA, 64'h300 + 64'(i));
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 64'h0, 1'b1, A_DATA);
      for (int i = 0; i < 8; i++) wr(A_DATA, 64'h200 + 64'(i));
      for (int i = 0; i < 8; i++) rd_exp("pop_wrap", A_DATA, 64'h200 + 64'(i));
      rd_exp("status_wrap", A_STAT, 64'h0000_0008_0001_0000);

      // Underflow, sticky clear, flush
      rd_exp("pop_empty", A_DATA, 64'h0);
      rd_exp("status_udf", A_STAT, 64'h0000_0008_0009_0000);
      wr(A_CTRL, 64'h2);
      rd_exp("status_clr", A_STAT, 64'h0000_0008_0001_0000);
      wr(A_DATA, 64'h55); wr(A_DATA, 64'h66);
      wr(A_CTRL, 64'h1);
      idle();
      chk("count_flush", 64'(count), 64'd0);
      rd_exp("pop_after_flush", A_DATA, 64'h0);
      wr(A_CTRL, 64'h3);
      rd_exp("ctrl_read", A_CTRL, 64'h0);

      // Same-cycle write and read cases
      step(1'b1, A_DATA, 64'h77, 1'b1, A_DATA);   // pop empty + push
      idle();
      chk("count_push_pop_empty", 64'(count), 64'd1);
      for (int i = 0; i < 7; i++) wr(A_DATA, 64'h400 + 64'(i));
      step(1'b1, A_DATA, 64'h4FF, 1'b1, A_DATA);  // full: push + pop
      idle();
      chk("count_full_push_pop", 64'(count), 64'd8);
      rd_exp("status_no_ovf", A_STAT, 64'h0000_0008_000A_0008);
      step(1'b1, A_CTRL, 64'h1, 1'b1, A_DATA);    // flush + pop
      @(posedge clk); #1;
      chk("flush_pop_data", rsp_data, 64'h400);
      chk("count_flush_pop", 64'(count), 64'd0);
      wr(A_CTRL, 64'h2);

      // Out-of-window accesses are ignored
      step(1'b1, 16'h0030, 64'h99, 1'b1, 16'h0030);
      @(posedge clk); #1;
      chk("oow_no_rsp", 64'(rsp_valid), 64'd0);
      chk("oow_count", 64'(count), 64'd0);
      step(1'b0, 16'h0, 64'h0, 1'b1, 16'h0021);
      idle();

      // Reset during a read burst
      wr(A_DATA, 64'h1); wr(A_DATA, 64'h2);
      step(1'b0, 16'h0, 64'h0, 1'b1, A_STAT);
      step(1'b0, 16'h0, 64'h0, 1'b1, A_PEEK);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_rsp_cancel", 64'(rsp_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      rd_exp("status_after_rst", A_STAT, 64'h0000_0008_0001_0000);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_fifo_ctrl.md
Name: mmio_fifo_ctrl

Overview:
MMIO-mapped queue controller inside the AFU, placed between the CCI-P c0 MMIO decode and the c2 read-response mux.
- Host writes to the DATA address push 64-bit words into an internal circular buffer.
- Host reads of DATA pop the oldest word; reads of PEEK return it without popping.
- STATUS/CTRL registers expose occupancy and sticky error flags, and accept flush and clear commands.
- Replaces the raw shift-enable buffer with occupancy tracking and defined full/empty behaviour.

Parameters:
DEPTH, 8, number of 64-bit entries; power of two, minimum 2
BASE_ADDR, 16'h0020, base of the 4-register window in 32-bit-word MMIO units (DATA=+0, STATUS=+2, CTRL=+4, PEEK=+6)

Ports:
clk  in  1  AFU clock
rst  in  1  synchronous, active-high reset
wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid)
wr_addr  in  16  MMIO write address (mmio hdr address)
wr_data  in  64  MMIO write data (rx.c0.data[63:0])
rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid)
rd_addr  in  16  MMIO read address
rd_tid  in  9  MMIO read transaction ID
rsp_valid  out  1  read response valid; drives tx.c2.mmioRdValid when set
rsp_tid  out  9  TID echoed from the request
rsp_data  out  64  response data
count  out  $clog2(DEPTH)+1  current occupancy (debug/status)

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - rsp_valid=0, rsp_tid=0, rsp_data=0, count=0.
  - Head and tail pointers=0; overflow and underflow sticky flags=0.
  - Storage contents are don't-care.
- Address hit: only the four window addresses are claimed. Any other address produces no response and no state change; the parent mux owns the DFH addresses and the default response.
- Read latency: exactly 1 cycle. A hit read in cycle N gives rsp_valid=1 in N+1 for one cycle, with rsp_tid = rd_tid of cycle N.
  - rsp_valid drops to 0 in any cycle with no hit read.
  - rsp_data/rsp_tid hold their last value while rsp_valid=0.
- Push (write DATA):
  - count<DEPTH: store at tail; tail+=1 mod DEPTH; count+=1.
  - count==DEPTH: write is dropped and overflow sticky is set.
- Pop (read DATA):
  - count>0: respond with the head entry; head+=1 mod DEPTH; count-=1.
  - count==0: respond with 64'h0 and set underflow sticky.
- PEEK read: respond with the head entry, or 0 if empty. No state change.
- STATUS read returns a 64-bit word:
  - [15:0] count, zero-extended.
  - [16] empty (count==0); [17] full (count==DEPTH).
  - [18] overflow sticky; [19] underflow sticky.
  - [47:32] DEPTH; all other bits 0.
  - The value reflects state before any same-cycle write.
- CTRL read returns 0. CTRL write:
  - bit0 flush: head=tail=0, count=0.
  - bit1: clear both sticky flags.
  - Both bits may be set together. Other bits are ignored.
- Simultaneous wr_valid and rd_valid (not legal on CCI-P, but defined here):
  - Both are processed in the same cycle. Full/empty checks use pre-cycle count.
  - Push to DATA when full with a same-cycle pop of DATA is accepted; count stays DEPTH.
  - Pop when empty with a same-cycle push: underflow response of 0 and sticky set; the push still lands; count=1.
  - CTRL flush together with a DATA pop: the pop response carries the pre-flush head; the final state is empty.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count is a separate counter, so full and empty are unambiguous.
- Reset mid-operation: a pending response is cancelled (rsp_valid=0 on the cycle after rst); the queue is emptied.

Decomposition:
- Package mmio_fifo_pkg holds:
  - Register offsets (OFF_DATA=0, OFF_STATUS=2, OFF_CTRL=4, OFF_PEEK=6).
  - STATUS bit positions and CTRL bit positions (CTRL_FLUSH=0, CTRL_CLR_STICKY=1).
  - Default DEPTH.
  - An enum t_mmio_fifo_op {OP_NONE, OP_PUSH, OP_POP, OP_PEEK, OP_STATUS, OP_CTRL} produced by the address decode.
- Sub-module mmio_fifo_store holds the DEPTHx64 array, head/tail/count, and push/pop/flush inputs, and reports full/empty/head_data.
- The top level does decode, sticky flags and the response register.

Test Plan:
- Reset, then read STATUS (0x22) -> after 1 cycle rsp_valid=1, data=0x0000_0008_0001_0000 (DEPTH=8, empty=1), TID echoed.
- Push 0xA1,0xA2,0xA3 to 0x20; PEEK (0x26) -> 0xA1 with count still 3; pop three times -> 0xA1,0xA2,0xA3; STATUS -> empty=1.
- Push 9 words 0x100..0x108 -> 9th dropped; STATUS bits [17]=1 and [18]=1, count=8; pops return 0x100..0x107.
- Wrap: push 6, pop 6, push 8 (0x200..0x207) -> pops return 0x200..0x207 in order with no overflow.
- Pop when empty -> data 0, underflow sticky set; write CTRL=0x2 -> STATUS [19:18]=0; push 2, write CTRL=0x1 -> count=0, next pop returns 0.
- Read 0x30 (out of window) -> no rsp_valid. Assert rst during a back-to-back read burst -> rsp_valid=0 the next cycle and count=0.
